crt_loader: RTL and testbench

Parses the CRT cartridge image byte stream from the HPS download channel (`ioctl_index == 3`) and turns it into cartridge descriptors and SDRAM write requests. It takes over the CRT path of the top level: the `ioctl_*` stream comes in on one side, and out go the cartridge-mapper bank table writes and byte writes to the SDRAM IEC-cycle arbiter. It tracks CHIP packets, aligns each bank to an 8 KB boundary, and back-pressures the downloader until each byte has been committed.

---
 rtl/crt_loader.sv | 208 ++++++++++++++++++++
 tb/tb_crt_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crt_loader.sv
// CRT cartridge image parser: turns the HPS download byte stream into bank
// descriptors and back-pressured SDRAM byte writes, one bank per 8 KB slot.
module crt_loader #(
  parameter logic [24:0] BASE_ADDR = 25'h100000,
  parameter logic [7:0]  HDR_LEN   = 8'h40
) (
  input  logic        clk32,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        detach,
  input  logic        mem_ack,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic [15:0] cart_id,
  output logic [7:0]  cart_exrom,
  output logic [7:0]  cart_game,
  output logic [7:0]  bank_type,
  output logic [15:0] bank_num,
  output logic [15:0] bank_laddr,
  output logic [15:0] bank_size,
  output logic [24:0] bank_raddr,
  output logic        bank_wr,
  output logic        cart_attached,
  output logic        bad_sig,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_FILEHDR, S_CHIPHDR, S_DATA} state_t;

  state_t      state_q;
  logic        dl_q;
  logic [3:0]  hc_q;
  logic [24:0] load_addr_q;
  logic [31:0] pkt_len_q;
  logic [31:0] blk_len_q;
  logic        wait_q;
  logic        mem_req_q;
  logic [24:0] mem_addr_q;
  logic [7:0]  mem_data_q;
  logic [15:0] cart_id_q;
  logic [7:0]  cart_exrom_q;
  logic [7:0]  cart_game_q;
  logic [7:0]  bank_type_q;
  logic [15:0] bank_num_q;
  logic [15:0] bank_laddr_q;
  logic [15:0] bank_size_q;
  logic [24:0] bank_raddr_q;
  logic        bank_wr_q;
  logic        attached_q;
  logic        bad_sig_q;
  logic        overrun_q;

  logic        strobe;
  logic        strobe_ok;
  logic        dl_rise;
  logic        hdr_past;
  logic        chip_byte;
  logic [3:0]  hc_eff;
  logic [24:0] aligned_addr;

  assign strobe       = ioctl_wr && ioctl_download && (ioctl_index == 8'd3);
  assign strobe_ok    = strobe && !wait_q;
  assign dl_rise      = ioctl_download && !dl_q && (ioctl_index == 8'd3);
  assign hdr_past     = ioctl_addr >= {17'd0, HDR_LEN};
  // The first byte past the file header is CHIP header byte 0.
  assign chip_byte    = strobe_ok && ((state_q == S_CHIPHDR) ||
                                      ((state_q == S_FILEHDR) && hdr_past));
  assign hc_eff       = (state_q == S_CHIPHDR) ? hc_q : 4'd0;
  assign aligned_addr = (load_addr_q[12:0] != 13'd0) ?
                        {load_addr_q[24:13] + 12'd1, 13'd0} : load_addr_q;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      dl_q         <= 1'b0;
      hc_q         <= 4'd0;
      load_addr_q  <= BASE_ADDR;
      pkt_len_q    <= 32'd0;
      blk_len_q    <= 32'd0;
      wait_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 25'd0;
      mem_data_q   <= 8'd0;
      cart_id_q    <= 16'd0;
      cart_exrom_q <= 8'd0;
      cart_game_q  <= 8'd0;
      bank_type_q  <= 8'd0;
      bank_num_q   <= 16'd0;
      bank_laddr_q <= 16'd0;
      bank_size_q  <= 16'd0;
      bank_raddr_q <= 25'd0;
      bank_wr_q    <= 1'b0;
      attached_q   <= 1'b0;
      bad_sig_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      bank_wr_q <= 1'b0;

      if (strobe && wait_q) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (dl_rise) begin
            state_q     <= S_FILEHDR;
            hc_q        <= 4'd0;
            load_addr_q <= BASE_ADDR;
            blk_len_q   <= 32'd0;
            attached_q  <= 1'b0;
            bad_sig_q   <= 1'b0;
            overrun_q   <= 1'b0;
          end
        end
        S_FILEHDR: begin
          if (strobe_ok && !hdr_past) begin
            case (ioctl_addr)
              25'h00:  if (ioctl_data != 8'h43) bad_sig_q <= 1'b1;
              25'h01:  if (ioctl_data != 8'h36) bad_sig_q <= 1'b1;
              25'h02:  if (ioctl_data != 8'h34) bad_sig_q <= 1'b1;
              25'h03:  if (ioctl_data != 8'h20) bad_sig_q <= 1'b1;
              25'h16:  cart_id_q[15:8] <= ioctl_data;
              25'h17:  cart_id_q[7:0]  <= ioctl_data;
              25'h18:  cart_exrom_q    <= ioctl_data;
              25'h19:  cart_game_q     <= ioctl_data;
              default: ;
            endcase
          end
        end
        S_DATA: begin
          if (strobe_ok) begin
            mem_req_q  <= 1'b1;
            wait_q     <= 1'b1;
            mem_addr_q <= load_addr_q;
            mem_data_q <= ioctl_data;
          end
        end
        default: ;
      endcase

      // Commit of the pending byte; the last one of a bank reopens the header.
      if (mem_req_q && mem_ack) begin
        mem_req_q   <= 1'b0;
        wait_q      <= 1'b0;
        load_addr_q <= load_addr_q + 25'd1;
        blk_len_q   <= blk_len_q - 32'd1;
        if (blk_len_q == 32'd1) begin
          state_q <= S_CHIPHDR;
          hc_q    <= 4'd0;
        end
      end

      if (chip_byte) begin
        state_q <= S_CHIPHDR;
        hc_q    <= hc_eff + 4'd1;
        case (hc_eff)
          4'd0:  load_addr_q <= aligned_addr;
          4'd4, 4'd5, 4'd6, 4'd7: pkt_len_q <= {pkt_len_q[23:0], ioctl_data};
          4'd8:  blk_len_q <= pkt_len_q - 32'd16;
          4'd9:  bank_type_q <= ioctl_data;
          4'd10: bank_num_q[15:8] <= ioctl_data;
          4'd11: bank_num_q[7:0] <= ioctl_data;
          4'd12: bank_laddr_q[15:8] <= ioctl_data;
          4'd13: bank_laddr_q[7:0] <= ioctl_data;
          4'd14: bank_size_q[15:8] <= ioctl_data;
          4'd15: begin
            bank_size_q[7:0] <= ioctl_data;
            bank_raddr_q     <= load_addr_q;
            bank_wr_q        <= 1'b1;
            state_q          <= (blk_len_q != 32'd0) ? S_DATA : S_CHIPHDR;
          end
          default: ;
        endcase
      end

      // Download end waits for any outstanding write before going idle.
      if ((state_q != S_IDLE) && !ioctl_download && !mem_req_q) begin
        state_q    <= S_IDLE;
        attached_q <= ~bad_sig_q;
      end

      if (detach) attached_q <= 1'b0;
    end
  end

  assign ioctl_wait    = wait_q;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign cart_id       = cart_id_q;
  assign cart_exrom    = cart_exrom_q;
  assign cart_game     = cart_game_q;
  assign bank_type     = bank_type_q;
  assign bank_num      = bank_num_q;
  assign bank_laddr    = bank_laddr_q;
  assign bank_size     = bank_size_q;
  assign bank_raddr    = bank_raddr_q;
  assign bank_wr       = bank_wr_q;
  assign cart_attached = attached_q;
  assign bad_sig       = bad_sig_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_crt_loader.sv
// Scoreboard bench for crt_loader: a file-level reference parser predicts bank
// descriptors and SDRAM writes; a monitor compares them as the DUT emits them.
module tb_crt_loader;

  localparam logic [24:0] BASE = 25'h100000;
  localparam int HDR = 64;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic [24:0] raddr;
    logic [7:0]  typ;
    logic [15:0] num;
    logic [15:0] laddr;
    logic [15:0] size;
  } bank_t;

  logic        clk32, reset_n, ioctl_download, ioctl_wr, detach, mem_ack;
  logic [7:0]  ioctl_index, ioctl_data;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait, mem_req, bank_wr, cart_attached, bad_sig, overrun;
  logic [24:0] mem_addr, bank_raddr;
  logic [7:0]  mem_data, cart_exrom, cart_game, bank_type;
  logic [15:0] cart_id, bank_num, bank_laddr, bank_size;

  crt_loader dut (
    .clk32(clk32), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .detach(detach), .mem_ack(mem_ack),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .cart_id(cart_id), .cart_exrom(cart_exrom),
    .cart_game(cart_game), .bank_type(bank_type), .bank_num(bank_num),
    .bank_laddr(bank_laddr), .bank_size(bank_size), .bank_raddr(bank_raddr),
    .bank_wr(bank_wr), .cart_attached(cart_attached), .bad_sig(bad_sig),
    .overrun(overrun)
  );

  int n_checks = 0;
  int n_err = 0;
  int n_writes = 0;
  int n_banks = 0;
  logic [7:0] img[$];
  wr_t   exp_wr[$];
  bank_t exp_bank[$];
  logic  ack_hold = 1'b0;
  logic  ack_rand = 1'b0;
  int    ack_dly = 3;

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk32);
    #1;
  endtask

  // SDRAM arbiter model: grants each request after a fixed or random delay.
  initial begin
    int d;
    mem_ack = 1'b0;
    forever begin
      cycle();
      if (mem_req && !ack_hold) begin
        d = ack_rand ? int'($urandom_range(0, 3)) : ack_dly;
        repeat (d) cycle();
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
      end
    end
  end

  // Monitor: pops expectations when a new write or bank descriptor appears.
  logic        req_prev = 1'b0, bw_prev = 1'b0;
  logic [24:0] held_addr = '0;
  logic [7:0]  held_data = '0;
  always @(negedge clk32) begin
    wr_t w;
    bank_t b;
    if (mem_req && !req_prev) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_data);
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", 32'(mem_data), 32'(w.data));
      end
      n_writes <= n_writes + 1;
      held_addr <= mem_addr;
      held_data <= mem_data;
    end else if (mem_req && req_prev) begin
      check("wr_stable", {mem_data, mem_addr[23:0]}, {held_data, held_addr[23:0]});
    end
    if (bank_wr) begin
      if (bw_prev) begin
        n_checks++; n_err++;
        $display("FAIL bank_wr_width: got 2+ cycles expected 1");
      end else if (exp_bank.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_bank: got raddr %0h expected none", bank_raddr);
      end else begin
        b = exp_bank.pop_front();
        check("bank_raddr", 32'(bank_raddr), 32'(b.raddr));
        check("bank_type", 32'(bank_type), 32'(b.typ));
        check("bank_num", 32'(bank_num), 32'(b.num));
        check("bank_laddr", 32'(bank_laddr), 32'(b.laddr));
        check("bank_size", 32'(bank_size), 32'(b.size));
      end
      n_banks <= n_banks + 1;
    end
    req_prev <= mem_req;
    bw_prev  <= bank_wr;
  end

  // Reference parser: walks CHIP packets of the whole image.
  task automatic model_image();
    int off, n;
    logic [24:0] addr;
    logic [31:0] len;
    bank_t b;
    wr_t w;
    off = HDR;
    addr = BASE;
    while (off + 16 <= img.size()) begin
      if (addr % 8192 != 0) addr = 25'((addr / 8192 + 1) * 8192);
      len = {img[off+4], img[off+5], img[off+6], img[off+7]};
      b.raddr = addr;
      b.typ   = img[off+9];
      b.num   = {img[off+10], img[off+11]};
      b.laddr = {img[off+12], img[off+13]};
      b.size  = {img[off+14], img[off+15]};
      exp_bank.push_back(b);
      n = int'(len) - 16;
      for (int i = 0; i < n && off + 16 + i < img.size(); i++) begin
        w.addr = addr;
        w.data = img[off+16+i];
        exp_wr.push_back(w);
        addr = addr + 25'd1;
      end
      off = off + 16 + n;
    end
  endtask

  task automatic add_header(input logic [31:0] sig, input logic [15:0] id,
                            input logic [7:0] ex, input logic [7:0] gm);
    string s;
    s = "C64 CARTRIDGE   ";
    img.delete();
    for (int i = 0; i < HDR; i++) img.push_back(8'h00);
    for (int i = 4; i < 16; i++) img[i] = s[i];
    img[0] = sig[31:24]; img[1] = sig[23:16]; img[2] = sig[15:8]; img[3] = sig[7:0];
    img[8'h13] = 8'h40; img[8'h14] = 8'h01;
    img[8'h16] = id[15:8]; img[8'h17] = id[7:0];
    img[8'h18] = ex; img[8'h19] = gm;
  endtask

  task automatic add_chip(input logic [31:0] len, input logic [15:0] typ, input logic [15:0] bank,
                          input logic [15:0] laddr, input logic [15:0] size, input int ndata);
    logic [7:0] hdr[16];
    hdr = '{8'h43, 8'h48, 8'h49, 8'h50, len[31:24], len[23:16], len[15:8], len[7:0],
            typ[15:8], typ[7:0], bank[15:8], bank[7:0], laddr[15:8], laddr[7:0],
            size[15:8], size[7:0]};
    for (int i = 0; i < 16; i++) img.push_back(hdr[i]);
    for (int i = 0; i < ndata; i++) img.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic wait_done);
    int t;
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1'b1;
    cycle();
    ioctl_wr = 1'b0;
    if (wait_done) begin
      t = 0;
      while (ioctl_wait && t < 200) begin
        cycle();
        t++;
      end
      if (t >= 200) begin
        n_checks++; n_err++;
        $display("FAIL wait_timeout: got ioctl_wait stuck at offset %0h expected release", a);
      end
    end
  endtask

  task automatic start_dl();
    ioctl_index = 8'd3;
    ioctl_download = 1'b1;
    cycle();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic run_image();
    model_image();
    start_dl();
    for (int i = 0; i < img.size(); i++) send_byte(25'(i), img[i], 1'b1);
    end_dl();
  endtask

  task automatic check_drained(input string name);
    check({name, "_wr_q"}, 32'(exp_wr.size()), 32'd0);
    check({name, "_bank_q"}, 32'(exp_bank.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [7:0] b0;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_data = '0; detach = 1'b0;
    repeat (3) cycle();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_wait", 32'(ioctl_wait), 0);
    reset_n = 1'b1;
    cycle();
    check("rst_outputs", {7'(cart_id), mem_addr}, 32'd0);
    check("rst_flags", {28'd0, cart_attached, bad_sig, overrun, bank_wr}, 32'd0);

    // Single 8 KB bank, fixed 3-cycle grant latency.
    add_header("C64 ", 16'h0005, 8'h00, 8'h01);
    add_chip(32'h2010, 16'h0000, 16'h0000, 16'h8000, 16'h2000, 8192);
    w0 = n_writes;
    run_image();
    check("t1_writes", 32'(n_writes - w0), 32'd8192);
    check("t1_banks", 32'(n_banks), 32'd1);
    check("t1_cart_id", 32'(cart_id), 32'h0005);
    check("t1_exrom", 32'(cart_exrom), 32'h00);
    check("t1_game", 32'(cart_game), 32'h01);
    check("t1_bad_sig", 32'(bad_sig), 0);
    check("t1_attached", 32'(cart_attached), 1);
    check_drained("t1");

    // Two banks: the second must land on the next 8 KB boundary.
    ack_rand = 1'b1;
    add_header("C64 ", 16'h0020, 8'h01, 8'h00);
    add_chip(32'h1010, 16'h0000, 16'h0000, 16'h8000, 16'h1000, 4096);
    add_chip(32'h0110, 16'h0002, 16'h0001, 16'hA000, 16'h0100, 256);
    run_image();
    check("t2_raddr", 32'(bank_raddr), 32'h102000);
    check("t2_num", 32'(bank_num), 32'h1);
    check("t2_type", 32'(bank_type), 32'h2);
    check("t2_cart_id", 32'(cart_id), 32'h0020);
    check("t2_attached", 32'(cart_attached), 1);
    check_drained("t2");

    // Detach after a valid load.
    detach = 1'b1;
    cycle();
    detach = 1'b0;
    check("detach_clear", 32'(cart_attached), 0);

    // Download end coinciding with detach.
    add_header("C64 ", 16'h0001, 8'h00, 8'h00);
    add_chip(32'h0014, 16'h0000, 16'h0000, 16'h8000, 16'h0004, 4);
    model_image();
    start_dl();
    for (int i = 0; i < img.size(); i++) send_byte(25'(i), img[i], 1'b1);
    ioctl_download = 1'b0;
    detach = 1'b1;
    cycle();
    detach = 1'b0;
    repeat (3) cycle();
    check("detach_same_cycle", 32'(cart_attached), 0);
    check_drained("t3");

    // Bad signature.
    add_header("C65 ", 16'h0000, 8'h00, 8'h00);
    add_chip(32'h0018, 16'h0000, 16'h0000, 16'h8000, 16'h0008, 8);
    run_image();
    check("bad_sig_set", 32'(bad_sig), 1);
    check("bad_attached", 32'(cart_attached), 0);
    check_drained("t4");

    // Second strobe while the first byte is still pending.
    ack_rand = 1'b0;
    add_header("C64 ", 16'h0005, 8'h00, 8'h01);
    add_chip(32'h0011, 16'h0000, 16'h0000, 16'h8000, 16'h0001, 1);
    model_image();
    w0 = n_writes;
    start_dl();
    for (int i = 0; i < HDR + 16; i++) send_byte(25'(i), img[i], 1'b1);
    ack_hold = 1'b1;
    b0 = img[HDR+16];
    ioctl_addr = 25'(HDR + 16);
    ioctl_data = b0;
    ioctl_wr = 1'b1;
    cycle();
    check("ovr_req_latency", 32'(mem_req), 1);
    check("ovr_wait_latency", 32'(ioctl_wait), 1);
    ioctl_data = ~b0;
    ioctl_addr = 25'(HDR + 17);
    cycle();
    ioctl_wr = 1'b0;
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_data", 32'(mem_data), 32'(b0));
    ack_hold = 1'b0;
    repeat (8) cycle();
    check("ovr_released", 32'(ioctl_wait), 0);
    end_dl();
    check("ovr_writes", 32'(n_writes - w0), 32'd1);
    check("ovr_sticky", 32'(overrun), 1);
    check_drained("t5");

    // Asynchronous reset in the middle of a data byte.
    add_header("C64 ", 16'h0007, 8'h00, 8'h01);
    add_chip(32'h0020, 16'h0000, 16'h0003, 16'h8000, 16'h0010, 16);
    exp_bank.push_back('{raddr: BASE, typ: 8'h00, num: 16'h0003, laddr: 16'h8000, size: 16'h0010});
    exp_wr.push_back('{addr: BASE, data: img[HDR+16]});
    start_dl();
    for (int i = 0; i < HDR + 16; i++) send_byte(25'(i), img[i], 1'b1);
    ack_hold = 1'b1;
    send_byte(25'(HDR + 16), img[HDR+16], 1'b0);
    cycle();
    check("pre_rst_req", 32'(mem_req), 1);
    #2;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_req), 0);
    check("async_rst_wait", 32'(ioctl_wait), 0);
    cycle();
    check("rst_ids", {cart_id, bank_num}, 32'd0);
    check("rst_bank", 32'(bank_raddr), 32'd0);
    check("rst_flags2", {28'd0, cart_attached, bad_sig, overrun, bank_wr}, 32'd0);
    reset_n = 1'b1;
    ack_hold = 1'b0;
    cycle();
    check_drained("t6");
    add_header("C64 ", 16'h0009, 8'h00, 8'h01);
    add_chip(32'h0018, 16'h0000, 16'h0000, 16'h8000, 16'h0008, 8);
    run_image();
    check("restart_raddr", 32'(bank_raddr), 32'(BASE));
    check("restart_attached", 32'(cart_attached), 1);
    check_drained("t7");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
